// File: rtl/memory_host_port.sv
// memory_host_port: single-outstanding host initiator for the 8x8-bit memory
// IC pin interface. A request is taken over a valid/ready handshake and
// driven onto the IC pins as a one-cycle select strobe. Read data is captured
// a fixed number of cycles later and returned over a valid/ready response
// channel. After a write, the block waits a fixed recovery time before it
// accepts the next request.
module memory_host_port #(
    parameter int READ_LATENCY   = 2,
    parameter int WRITE_RECOVERY = 1
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [2:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       mem_select,
    output logic       mem_operation,
    output logic [2:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic [7:0] rd_count,
    output logic [7:0] wr_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] RD_LAT  = 4'(READ_LATENCY);
    localparam logic [3:0] WR_REC  = 4'(WRITE_RECOVERY);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       accept;
    logic       last_wait;

    // The pin registers double as the holding registers for the request.
    logic       mem_select_q;
    logic       mem_operation_q;
    logic [2:0] mem_addr_q;
    logic [7:0] mem_wdata_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_rdata_q;
    logic [7:0] rd_count_q;
    logic [7:0] wr_count_q;

    assign req_ready = (state_q == S_IDLE) && !i_reset;
    assign accept    = (state_q == S_IDLE) && req_valid;
    assign last_wait = (state_q == S_WAIT) && (cnt_q == 4'd1);

    // Next-state logic and wait counter sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_operation_q) begin
                    cnt_d   = WR_REC;
                    state_d = (WR_REC == 4'd0) ? S_IDLE : S_WAIT;
                end else begin
                    cnt_d   = RD_LAT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = mem_operation_q ? S_IDLE : S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, pin, response and counter registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= 4'd0;
            mem_select_q    <= 1'b0;
            mem_operation_q <= 1'b0;
            mem_addr_q      <= 3'd0;
            mem_wdata_q     <= 8'd0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= 8'd0;
            rd_count_q      <= 8'd0;
            wr_count_q      <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            // Strobe is high exactly during the cycle after acceptance.
            mem_select_q <= accept;
            if (accept) begin
                mem_operation_q <= req_write;
                mem_addr_q      <= req_addr;
                mem_wdata_q     <= req_wdata;
                if (req_write) begin
                    wr_count_q <= wr_count_q + 8'd1;
                end else begin
                    rd_count_q <= rd_count_q + 8'd1;
                end
            end
            if (last_wait && !mem_operation_q) begin
                rsp_rdata_q <= mem_rdata;
                rsp_valid_q <= 1'b1;
            end else if ((state_q == S_RESP) && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign mem_select    = mem_select_q;
    assign mem_operation = mem_operation_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rd_count      = rd_count_q;
    assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_memory_host_port.sv
// Bench for memory_host_port: three instances (default timing, fastest
// timing, slowest read latency) each with a small IC model that presents
// valid read data only in the cycle the read must be sampled.
module tb_memory_host_port;

    logic clk = 1'b0;
    logic i_reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    // Cycle n is the interval that starts at rising edge n.
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]      req_valid = '0;
    logic [2:0]      req_write = '0;
    logic [2:0][2:0] req_addr  = '0;
    logic [2:0][7:0] req_wdata = '0;
    logic [2:0]      rsp_ready = '1;
    logic [2:0]      req_ready;
    logic [2:0]      rsp_valid;
    logic [2:0][7:0] rsp_rdata;
    logic [2:0]      mem_select;
    logic [2:0]      mem_operation;
    logic [2:0][2:0] mem_addr;
    logic [2:0][7:0] mem_wdata;
    logic [2:0][7:0] mem_rdata;
    logic [2:0][7:0] rd_count;
    logic [2:0][7:0] wr_count;

    logic [2:0] ovr_en  = '0;
    logic [7:0] ovr_val = 8'h00;

    int rl_tab[3] = '{2, 1, 15};
    int wr_tab[3] = '{1, 0, 0};

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int RL = (gi == 0) ? 2 : ((gi == 1) ? 1 : 15);
        localparam int WR = (gi == 0) ? 1 : 0;
        logic [7:0] ic_mem [8] = '{default: 8'h00};
        int         age = 0;

        // IC model: store on write strobe, count cycles since last strobe.
        always @(posedge clk) begin
            if (mem_select[gi]) begin
                age <= 1;
                if (mem_operation[gi]) ic_mem[mem_addr[gi]] <= mem_wdata[gi];
            end else if (age != 0 && age < 100) begin
                age <= age + 1;
            end
        end

        assign mem_rdata[gi] = ovr_en[gi] ? ovr_val :
                               ((age == RL) ? ic_mem[mem_addr[gi]] : 8'hEE);

        memory_host_port #(
            .READ_LATENCY  (RL),
            .WRITE_RECOVERY(WR)
        ) u_dut (
            .i_clock      (clk),
            .i_reset      (i_reset),
            .req_valid    (req_valid[gi]),
            .req_ready    (req_ready[gi]),
            .req_write    (req_write[gi]),
            .req_addr     (req_addr[gi]),
            .req_wdata    (req_wdata[gi]),
            .rsp_valid    (rsp_valid[gi]),
            .rsp_ready    (rsp_ready[gi]),
            .rsp_rdata    (rsp_rdata[gi]),
            .mem_select   (mem_select[gi]),
            .mem_operation(mem_operation[gi]),
            .mem_addr     (mem_addr[gi]),
            .mem_wdata    (mem_wdata[gi]),
            .mem_rdata    (mem_rdata[gi]),
            .rd_count     (rd_count[gi]),
            .wr_count     (wr_count[gi])
        );
    end

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [7:0] exp_rd[3] = '{default: 8'h00};
    logic [7:0] exp_wr[3] = '{default: 8'h00};
    logic [7:0] shadow[3][8] = '{default: '{default: 8'h00}};
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input int idx);
        check("rst_select", 32'(mem_select[idx]), 0);
        check("rst_operation", 32'(mem_operation[idx]), 0);
        check("rst_addr", 32'(mem_addr[idx]), 0);
        check("rst_wdata", 32'(mem_wdata[idx]), 0);
        check("rst_rsp_valid", 32'(rsp_valid[idx]), 0);
        check("rst_rsp_rdata", 32'(rsp_rdata[idx]), 0);
        check("rst_rd_count", 32'(rd_count[idx]), 0);
        check("rst_wr_count", 32'(wr_count[idx]), 0);
    endtask

    // Present a request at the current falling edge and hold it until taken.
    // Returns at the falling edge of cycle k+1 (the expected ISSUE cycle).
    task automatic issue(input int idx, input logic w, input logic [2:0] a,
                         input logic [7:0] d, output int k);
        int t = 0;
        req_write[idx] = w;
        req_addr[idx]  = a;
        req_wdata[idx] = d;
        req_valid[idx] = 1'b1;
        while (!req_ready[idx] && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("accept", 32'(req_ready[idx]), 1);
        k = cyc;
        if (w) exp_wr[idx]++;
        else   exp_rd[idx]++;
        @(negedge clk);
        req_valid[idx] = 1'b0;
    endtask

    task automatic do_write(input int idx, input logic [2:0] a, input logic [7:0] d);
        int   k;
        int   t;
        logic seen;
        issue(idx, 1'b1, a, d, k);
        shadow[idx][a] = d;
        check("wr_select", 32'(mem_select[idx]), 1);
        check("wr_operation", 32'(mem_operation[idx]), 1);
        check("wr_addr", 32'(mem_addr[idx]), 32'(a));
        check("wr_wdata", 32'(mem_wdata[idx]), 32'(d));
        @(negedge clk);
        check("wr_select_drop", 32'(mem_select[idx]), 0);
        seen = 1'b0;
        t = 1;
        while (!req_ready[idx] && t < 50) begin
            if (rsp_valid[idx]) seen = 1'b1;
            @(negedge clk);
            t++;
        end
        check("wr_ready_cycle", 32'(cyc), 32'(k + 2 + wr_tab[idx]));
        check("wr_no_rsp", 32'({seen, rsp_valid[idx]}), 0);
        check("wr_count", 32'(wr_count[idx]), 32'(exp_wr[idx]));
    endtask

    task automatic do_read(input int idx, input logic [2:0] a);
        int k;
        int t = 0;
        exp_q.push_back(shadow[idx][a]);
        issue(idx, 1'b0, a, 8'h00, k);
        check("rd_select", 32'(mem_select[idx]), 1);
        check("rd_operation", 32'(mem_operation[idx]), 0);
        check("rd_addr", 32'(mem_addr[idx]), 32'(a));
        while (!rsp_valid[idx] && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("rd_rsp_cycle", 32'(cyc), 32'(k + 2 + rl_tab[idx]));
        check("rd_data", 32'(rsp_rdata[idx]), 32'(exp_q.pop_front()));
        check("rd_count", 32'(rd_count[idx]), 32'(exp_rd[idx]));
        if (rsp_ready[idx]) begin
            @(negedge clk);
            check("rd_ready_back", 32'(req_ready[idx]), 1);
            check("rd_rsp_drop", 32'(rsp_valid[idx]), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         k;
        logic [7:0] held;
        logic       seen;

        // Reset and reset values.
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready[0]), 0);
        i_reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_reset(i);
        check("idle_req_ready", 32'(req_ready[0]), 1);

        // Default timing: single write then read of the same byte.
        do_write(0, 3'd3, 8'hA5);
        do_read(0, 3'd3);

        // Fill all addresses, read them back.
        for (int a = 0; a < 8; a++) do_write(0, 3'(a), 8'(8'h10 + a));
        for (int a = 0; a < 8; a++) do_read(0, 3'(a));

        // Response back-pressure while IC data changes and a request waits.
        rsp_ready[0] = 1'b0;
        held = shadow[0][5];
        do_read(0, 3'd5);
        req_write[0] = 1'b1;
        req_addr[0]  = 3'd2;
        req_wdata[0] = 8'h3C;
        req_valid[0] = 1'b1;
        ovr_en[0]    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ovr_val = 8'(i * 17 + 1);
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid[0]), 1);
            check("hold_rsp_rdata", 32'(rsp_rdata[0]), 32'(held));
            check("hold_req_ready", 32'(req_ready[0]), 0);
        end
        check("hold_no_select", 32'(mem_select[0]), 0);
        check("hold_wr_count", 32'(wr_count[0]), 32'(exp_wr[0]));
        rsp_ready[0] = 1'b1;
        ovr_en[0]    = 1'b0;
        @(negedge clk);
        check("hold_release_ready", 32'(req_ready[0]), 1);
        check("hold_release_rsp", 32'(rsp_valid[0]), 0);
        exp_wr[0]++;
        shadow[0][2] = 8'h3C;
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("held_req_select", 32'(mem_select[0]), 1);
        check("held_req_addr", 32'(mem_addr[0]), 2);
        check("held_req_wdata", 32'(mem_wdata[0]), 32'h3C);
        repeat (3) @(negedge clk);
        check("held_req_wr_count", 32'(wr_count[0]), 32'(exp_wr[0]));
        do_read(0, 3'd2);

        // Reset during WAIT of a read abandons it.
        issue(0, 1'b0, 3'd6, 8'h00, k);
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        check_reset(0);
        check("rst_wait_req_ready", 32'(req_ready[0]), 0);
        i_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_rd[i] = 8'h00;
            exp_wr[i] = 8'h00;
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid[0] || mem_select[0]) seen = 1'b1;
        end
        check("rst_no_late_activity", 32'(seen), 0);
        do_write(0, 3'd6, 8'h77);
        do_read(0, 3'd6);

        // Counter wrap over 256 back-to-back writes.
        for (int i = 0; i < 256; i++) do_write(0, 3'(i), 8'(i));
        check("wr_count_wrap", 32'(wr_count[0]), 32'(exp_wr[0]));

        // Latency sweep: READ_LATENCY 1 and 15, WRITE_RECOVERY 0.
        do_write(1, 3'd1, 8'h5A);
        do_write(1, 3'd4, 8'hC3);
        do_read(1, 3'd1);
        do_read(1, 3'd4);
        do_write(2, 3'd7, 8'h96);
        do_read(2, 3'd7);
        do_read(2, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
